handshake_fifo_break_dv: RTL
============================

HANDSHAKE_FIFO_BREAK_DV -- requirements
Module: handshake_fifo_break_dv

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of the data token.
REQ-002 Parameter DEPTH, default 4, number of storage slots; legal range 1..64.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 ins  input  DATA_WIDTH  upstream data token, e.g. driven by a constant stage.
REQ-006 ins_valid  input  1  upstream token present.
REQ-007 ins_ready  output  1  FIFO accepts a token this cycle.
REQ-008 outs  output  DATA_WIDTH  head-of-queue token.
REQ-009 outs_valid  output  1  head token valid.
REQ-010 outs_ready  input  1  downstream accepts head token.

Function
REQ-011 Storage: DEPTH x DATA_WIDTH register array, write pointer wp, read pointer rp, occupancy count cnt of width clog2(DEPTH+1).
REQ-012 Push: occurs on a rising edge when ins_valid=1 and ins_ready=1; ins written to slot wp; wp advances.
REQ-013 Pop: occurs on a rising edge when outs_valid=1 and outs_ready=1; rp advances.
REQ-014 Pointer wrap: wp and rp go from DEPTH-1 to 0; no power-of-two assumption on DEPTH.
REQ-015 ins_ready = (cnt != DEPTH).
REQ-016 ins_ready is a function of registered state only, with no combinational path from outs_ready.
REQ-017 outs_valid = (cnt != 0); outs = array[rp]; both are registered-state driven.
REQ-018 There is no combinational path from ins_valid or ins to outs_valid or outs.
REQ-019 Latency: a token pushed at edge N is visible on outs with outs_valid=1 after edge N when the FIFO was empty, so minimum latency is 1 cycle.
REQ-020 Ordering: tokens leave in strict arrival order; no token is dropped or duplicated.
REQ-021 Simultaneous push and pop in the same cycle leaves cnt unchanged; both pointers advance.
REQ-022 Push only increments cnt by 1; pop only decrements cnt by 1.
REQ-023 Full (cnt=DEPTH): ins_ready=0, so no push occurs even when a pop occurs that cycle; ins_ready returns to 1 the cycle after the pop.
REQ-024 Empty (cnt=0): outs_valid=0 and no pop occurs; outs holds the stale array value, which is don't-care.
REQ-025 Stability: while outs_valid=1 and outs_ready=0, outs and outs_valid hold unchanged.
REQ-026 DEPTH=1: the block behaves as a single-slot breaking buffer with throughput of one token per 2 cycles.
REQ-027 For DEPTH>=2, sustained throughput is 1 token/cycle once cnt is between 1 and DEPTH-1.

Reset
REQ-028 rst=0 asynchronously forces wp=0, rp=0 and cnt=0, without waiting for a clock edge.
REQ-029 During reset: outs_valid=0 and ins_ready=1.
REQ-030 Array contents are not reset.
REQ-031 Reset asserted mid-operation discards all stored tokens immediately.
REQ-032 After rst rises, the first push is accepted on the first rising edge with ins_valid=1.

Verification
REQ-033 Single token: DEPTH=4, ins=12, ins_valid=1 for one cycle, outs_ready=1 -> outs=12 with outs_valid=1 exactly one cycle later, then outs_valid=0.
REQ-034 Fill and block: outs_ready=0, push 12,13,14,15 -> ins_ready=0 after 4th push and 5th token held upstream; then outs_ready=1 -> outputs 12,13,14,15 in order.
REQ-035 Streaming: ins_valid=1 and outs_ready=1 continuously with incrementing data 0..99 -> 100 tokens out in order, one per cycle after a 1-cycle fill, with cnt constant at 1.
REQ-036 Wrap-around: DEPTH=3, 10 push/pop pairs with random outs_ready stalls -> order is preserved across pointer wrap and no cnt overflow or underflow.
REQ-037 Full with simultaneous pop: cnt=DEPTH, ins_valid=1, outs_ready=1 -> one pop, no push that cycle, cnt=DEPTH-1, and ins_ready=1 on the next cycle.
REQ-038 Async reset: rst=0 asserted between clock edges with cnt=2 -> outs_valid drops to 0 and ins_ready rises to 1 before the next edge; no stale token appears after release.

Source files
------------

// File: rtl/handshake_fifo_break_dv.sv
// Valid/ready FIFO that breaks both handshake paths: ins_ready and outs/outs_valid come only from registers.
// Latency: 1 cycle from push to head when empty. Backpressure: ins_ready drops only when all DEPTH slots hold tokens.
module handshake_fifo_break_dv #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wp;
  logic [PW-1:0]         rp;
  logic [CW-1:0]         cnt;
  logic                  push;
  logic                  pop;

  assign ins_ready  = (cnt != CW'(DEPTH));
  assign outs_valid = (cnt != '0);
  assign outs       = mem[rp];

  assign push = ins_valid & ins_ready;
  assign pop  = outs_valid & outs_ready;

  // Storage is deliberately left out of reset; cnt alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp] <= ins;
    end
  end

  // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        wp <= (wp == PW'(DEPTH - 1)) ? '0 : wp + PW'(1);
      end
      if (pop) begin
        rp <= (rp == PW'(DEPTH - 1)) ? '0 : rp + PW'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
